// File: rtl/regfile_seq.sv
// regfile_seq: request sequencer driving a register file for READ/WRITE/COPY/NOP with registered outputs.
module regfile_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_src,
  input  logic [2:0] req_dst,
  input  logic [1:0] req_sel,
  output logic       rf_we,
  output logic [1:0] rf_mux_sel,
  output logic [2:0] rf_read_seg,
  output logic [2:0] rf_write_seg,
  output logic [7:0] rf_a_out,
  input  logic [7:0] rf_dout_a,
  input  logic [7:0] rf_dout_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_a,
  output logic [7:0] rsp_b,
  output logic [7:0] op_count
);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] SEL_A_IN = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, RSP, WR} state_t;

  state_t     state_q, state_d;
  logic       copy_q, copy_d;
  logic [2:0] dst_q, dst_d;
  logic       ready_q, we_q, vld_q;
  logic [1:0] mux_q, mux_d;
  logic [2:0] rseg_q, rseg_d, wseg_q, wseg_d;
  logic [7:0] aout_q, aout_d, rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d, cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    copy_d  = copy_q;
    dst_d   = dst_q;
    mux_d   = mux_q;
    rseg_d  = rseg_q;
    wseg_d  = wseg_q;
    aout_d  = aout_q;
    rsp_a_d = rsp_a_q;
    rsp_b_d = rsp_b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        copy_d = req_op == OP_COPY;
        dst_d  = req_dst;
        if (req_op == OP_READ || req_op == OP_COPY) begin
          state_d = RD_ADDR;
          rseg_d  = req_src;
        end else if (req_op == OP_WRITE) begin
          state_d = WR;
          mux_d   = req_sel;
          wseg_d  = req_dst;
        end else
          cnt_d = cnt_q + 8'd1;
      end
      RD_ADDR: state_d = RD_CAP;
      // read data is valid in this cycle, one cycle after the address was presented
      RD_CAP: if (copy_q) begin
        state_d = WR;
        aout_d  = rf_dout_a;
        mux_d   = SEL_A_IN;
        wseg_d  = dst_q;
      end else begin
        state_d = RSP;
        rsp_a_d = rf_dout_a;
        rsp_b_d = rf_dout_b;
      end
      RSP: if (rsp_ready) begin
        state_d = IDLE;
        cnt_d   = cnt_q + 8'd1;
      end
      WR: begin
        state_d = IDLE;
        cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      copy_q  <= 1'b0;
      dst_q   <= '0;
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      vld_q   <= 1'b0;
      mux_q   <= '0;
      rseg_q  <= '0;
      wseg_q  <= '0;
      aout_q  <= '0;
      rsp_a_q <= '0;
      rsp_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      copy_q  <= copy_d;
      dst_q   <= dst_d;
      ready_q <= state_d == IDLE;
      we_q    <= state_d == WR;
      vld_q   <= state_d == RSP;
      mux_q   <= mux_d;
      rseg_q  <= rseg_d;
      wseg_q  <= wseg_d;
      aout_q  <= aout_d;
      rsp_a_q <= rsp_a_d;
      rsp_b_q <= rsp_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready    = ready_q;
  assign rf_we        = we_q;
  assign rf_mux_sel   = mux_q;
  assign rf_read_seg  = rseg_q;
  assign rf_write_seg = wseg_q;
  assign rf_a_out     = aout_q;
  assign rsp_valid    = vld_q;
  assign rsp_a        = rsp_a_q;
  assign rsp_b        = rsp_b_q;
  assign op_count     = cnt_q;
endmodule

// File: tb/tb_regfile_seq.sv
// tb_regfile_seq: transaction-level model of the sequencer checked against regfile_seq with table, random and corner sequences.
module tb_regfile_seq;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic       clk, clr, req_valid, req_ready, rf_we, rsp_valid, rsp_ready;
  logic [1:0] req_op, req_sel, rf_mux_sel;
  logic [2:0] req_src, req_dst, rf_read_seg, rf_write_seg;
  logic [7:0] rf_a_out, rf_dout_a, rf_dout_b, rsp_a, rsp_b, op_count;

  typedef struct {
    logic [1:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [1:0] sel;
    logic [7:0] da;
    logic [7:0] db;
    int         hold;
  } vec_t;

  int         vectors = 0;
  int         misc = 0;
  logic [7:0] cnt = 0;
  logic [7:0] exp_aout = 0;
  vec_t       tbl[6];

  regfile_seq dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_src(req_src), .req_dst(req_dst), .req_sel(req_sel),
    .rf_we(rf_we), .rf_mux_sel(rf_mux_sel), .rf_read_seg(rf_read_seg),
    .rf_write_seg(rf_write_seg), .rf_a_out(rf_a_out), .rf_dout_a(rf_dout_a),
    .rf_dout_b(rf_dout_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .op_count(op_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_check();
    check("rst_ready", 8'(req_ready), 8'd1);
    check("rst_we", 8'(rf_we), 8'd0);
    check("rst_mux", 8'(rf_mux_sel), 8'd0);
    check("rst_rseg", 8'(rf_read_seg), 8'd0);
    check("rst_wseg", 8'(rf_write_seg), 8'd0);
    check("rst_aout", rf_a_out, 8'd0);
    check("rst_vld", 8'(rsp_valid), 8'd0);
    check("rst_rsp_a", rsp_a, 8'd0);
    check("rst_rsp_b", rsp_b, 8'd0);
    check("rst_count", op_count, 8'd0);
  endtask

  task automatic scramble();
    req_op    = 2'($urandom());
    req_src   = 3'($urandom());
    req_dst   = 3'($urandom());
    req_sel   = 2'($urandom());
    rf_dout_a = 8'($urandom());
    rf_dout_b = 8'($urandom());
  endtask

  // called at a negedge with the sequencer idle; returns at a negedge with it idle again
  task automatic run_op(input vec_t v);
    check("idle_ready", 8'(req_ready), 8'd1);
    req_valid = 1; req_op = v.op; req_src = v.src; req_dst = v.dst; req_sel = v.sel;
    @(negedge clk);
    req_valid = 0;
    scramble();
    rsp_ready = 1'($urandom());
    if (v.op == OP_NOP) begin
      cnt++;
      check("nop_ready", 8'(req_ready), 8'd1);
      check("nop_we", 8'(rf_we), 8'd0);
      check("nop_count", op_count, cnt);
    end else if (v.op == OP_WRITE) begin
      check("wr_we", 8'(rf_we), 8'd1);
      check("wr_mux", 8'(rf_mux_sel), 8'(v.sel));
      check("wr_wseg", 8'(rf_write_seg), 8'(v.dst));
      check("wr_ready", 8'(req_ready), 8'd0);
      check("wr_vld", 8'(rsp_valid), 8'd0);
      @(negedge clk);
      cnt++;
      check("wr_done_we", 8'(rf_we), 8'd0);
      check("wr_done_ready", 8'(req_ready), 8'd1);
      check("wr_done_count", op_count, cnt);
    end else begin
      check("rda_rseg", 8'(rf_read_seg), 8'(v.src));
      check("rda_ready", 8'(req_ready), 8'd0);
      check("rda_we", 8'(rf_we), 8'd0);
      @(negedge clk);
      rf_dout_a = v.da; rf_dout_b = v.db;
      check("rdc_we", 8'(rf_we), 8'd0);
      check("rdc_vld", 8'(rsp_valid), 8'd0);
      @(negedge clk);
      scramble();
      if (v.op == OP_COPY) begin
        exp_aout = v.da;
        check("cp_aout", rf_a_out, exp_aout);
        check("cp_we", 8'(rf_we), 8'd1);
        check("cp_mux", 8'(rf_mux_sel), 8'd2);
        check("cp_wseg", 8'(rf_write_seg), 8'(v.dst));
        check("cp_vld", 8'(rsp_valid), 8'd0);
        @(negedge clk);
        cnt++;
        check("cp_done_we", 8'(rf_we), 8'd0);
        check("cp_done_vld", 8'(rsp_valid), 8'd0);
        check("cp_done_ready", 8'(req_ready), 8'd1);
        check("cp_done_count", op_count, cnt);
      end else begin
        for (int i = 0; i <= v.hold; i++) begin
          check("rsp_vld", 8'(rsp_valid), 8'd1);
          check("rsp_a", rsp_a, v.da);
          check("rsp_b", rsp_b, v.db);
          check("rsp_ready_lo", 8'(req_ready), 8'd0);
          check("rsp_count", op_count, cnt);
          rsp_ready = (i == v.hold);
          @(negedge clk);
        end
        rsp_ready = 0;
        cnt++;
        check("rd_done_vld", 8'(rsp_valid), 8'd0);
        check("rd_done_ready", 8'(req_ready), 8'd1);
        check("rd_done_count", op_count, cnt);
      end
    end
    check("aout_hold", rf_a_out, exp_aout);
  endtask

  initial begin
    clr = 0; req_valid = 0; rsp_ready = 0;
    req_op = 0; req_src = 0; req_dst = 0; req_sel = 0; rf_dout_a = 0; rf_dout_b = 0;
    #2 clr = 1;
    #1 reset_check();
    @(negedge clk);
    clr = 0;
    @(negedge clk);
    check("post_rst_ready", 8'(req_ready), 8'd1);

    tbl[0] = '{op: OP_WRITE, src: 3'd0, dst: 3'd1, sel: 2'd3, da: 8'h00, db: 8'h00, hold: 0};
    tbl[1] = '{op: OP_READ,  src: 3'd1, dst: 3'd0, sel: 2'd0, da: 8'hFE, db: 8'hAB, hold: 3};
    tbl[2] = '{op: OP_COPY,  src: 3'd0, dst: 3'd2, sel: 2'd0, da: 8'hCF, db: 8'h12, hold: 0};
    tbl[3] = '{op: OP_NOP,   src: 3'd7, dst: 3'd7, sel: 2'd1, da: 8'h00, db: 8'h00, hold: 0};
    tbl[4] = '{op: OP_COPY,  src: 3'd5, dst: 3'd5, sel: 2'd1, da: 8'h5A, db: 8'hA5, hold: 0};
    tbl[5] = '{op: OP_READ,  src: 3'd7, dst: 3'd3, sel: 2'd2, da: 8'h00, db: 8'hFF, hold: 0};
    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // request held while busy is taken on the first idle cycle
    req_valid = 1; req_op = OP_READ; req_src = 3'd3;
    @(negedge clk);
    req_op = OP_WRITE; req_dst = 3'd5; req_sel = 2'd1;
    check("busy_rda_ready", 8'(req_ready), 8'd0);
    @(negedge clk);
    rf_dout_a = 8'h11; rf_dout_b = 8'h22;
    check("busy_rdc_we", 8'(rf_we), 8'd0);
    @(negedge clk);
    check("busy_rsp_vld", 8'(rsp_valid), 8'd1);
    check("busy_rsp_a", rsp_a, 8'h11);
    check("busy_rsp_we", 8'(rf_we), 8'd0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    cnt++;
    check("busy_idle_ready", 8'(req_ready), 8'd1);
    check("busy_idle_we", 8'(rf_we), 8'd0);
    check("busy_idle_count", op_count, cnt);
    @(negedge clk);
    req_valid = 0;
    check("busy_wr_we", 8'(rf_we), 8'd1);
    check("busy_wr_wseg", 8'(rf_write_seg), 8'd5);
    check("busy_wr_mux", 8'(rf_mux_sel), 8'd1);
    @(negedge clk);
    cnt++;
    check("busy_done_count", op_count, cnt);

    for (int n = 0; n < 300; n++) begin
      vec_t v;
      v.op = 2'($urandom()); v.src = 3'($urandom()); v.dst = 3'($urandom());
      v.sel = 2'($urandom()); v.da = 8'($urandom()); v.db = 8'($urandom());
      v.hold = $urandom_range(0, 3);
      run_op(v);
    end

    // clr during WR
    req_valid = 1; req_op = OP_WRITE; req_dst = 3'd6; req_sel = 2'd2;
    @(negedge clk);
    req_valid = 0;
    check("clrwr_we", 8'(rf_we), 8'd1);
    #2 clr = 1;
    #1 reset_check();
    cnt = 0; exp_aout = 0;
    @(negedge clk);
    clr = 0;
    repeat (2) begin
      @(negedge clk);
      check("clrwr_after_we", 8'(rf_we), 8'd0);
      check("clrwr_after_ready", 8'(req_ready), 8'd1);
      check("clrwr_after_count", op_count, cnt);
    end

    // clr during RSP
    req_valid = 1; req_op = OP_READ; req_src = 3'd4;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rf_dout_a = 8'h77; rf_dout_b = 8'h88;
    @(negedge clk);
    check("clrrsp_vld", 8'(rsp_valid), 8'd1);
    #2 clr = 1;
    #1 reset_check();
    @(negedge clk);
    clr = 0;
    rsp_ready = 1;
    repeat (2) begin
      @(negedge clk);
      check("clrrsp_after_vld", 8'(rsp_valid), 8'd0);
      check("clrrsp_after_we", 8'(rf_we), 8'd0);
      check("clrrsp_after_count", op_count, cnt);
    end
    rsp_ready = 0;

    // 256 back-to-back NOPs from reset wrap the counter
    req_valid = 1; req_op = OP_NOP;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      cnt++;
      check("nop_run_ready", 8'(req_ready), 8'd1);
      check("nop_run_count", op_count, cnt);
    end
    req_valid = 0;
    check("nop_wrap", op_count, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end
endmodule
